// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and port ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between core and DMA, with a saturating starvation counter
// that forces a DMA win after STARVE_LIM lost contested arbitrations.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic arb,
  output logic winner
);

  localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             dma_due;

  always_comb begin
    dma_due = (STARVE_LIM != 0) && (starve_cnt_q == LIM);
    winner  = PORT_CPU;
    if (dma_req && (!cpu_req || dma_due)) winner = PORT_DMA;

    // Only a contested loss counts; an idle DMA leaves the count untouched.
    starve_cnt_d = starve_cnt_q;
    if (arb && dma_req) begin
      if (winner == PORT_DMA) starve_cnt_d = '0;
      else if (starve_cnt_q != LIM) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Sequences core (C) and DMA (D) accesses onto one unified memory:
// IDLE arbitrates, ACCESS issues one mem_en cycle, WAIT covers read latency, RESP pulses ready.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_dma
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until its
  // one-cycle ready pulse; rdata is valid in that cycle and held afterwards.
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              lat_id_q, lat_id_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ready_q, cpu_ready_d, dma_ready_q, dma_ready_d;
  logic              gnt_dma_q, gnt_dma_d;
  logic              winner;

  mem_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
    .clk    (clk),
    .reset  (reset),
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .arb    (state_q == IDLE),
    .winner (winner)
  );

  always_comb begin
    state_d     = state_q;
    lat_id_d    = lat_id_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_cnt_d   = lat_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    gnt_dma_d   = gnt_dma_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          lat_id_d = winner;
          if (winner == PORT_DMA) begin
            lat_we_d = dma_we; lat_addr_d = dma_addr; lat_wdata_d = dma_wdata;
          end else begin
            lat_we_d = cpu_we; lat_addr_d = cpu_addr; lat_wdata_d = cpu_wdata;
          end
          mem_en_d    = 1'b1;
          mem_we_d    = lat_we_d;
          mem_addr_d  = lat_addr_d;
          mem_wdata_d = lat_wdata_d;
          gnt_dma_d   = (winner == PORT_DMA);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_we_q) begin
          state_d     = RESP;
          cpu_ready_d = (lat_id_q == PORT_CPU);
          dma_ready_d = (lat_id_q == PORT_DMA);
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      WAIT: begin
        // Last wait cycle is exactly MEM_LAT cycles after mem_en: data is valid now.
        if (lat_cnt_q == '0) begin
          if (lat_id_q == PORT_DMA) dma_rdata_d = mem_rdata;
          else                      cpu_rdata_d = mem_rdata;
          state_d     = RESP;
          cpu_ready_d = (lat_id_q == PORT_CPU);
          dma_ready_d = (lat_id_q == PORT_DMA);
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        state_d   = IDLE;
        gnt_dma_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_id_q    <= PORT_CPU;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_cnt_q   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      gnt_dma_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_id_q    <= lat_id_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      gnt_dma_q   <= gnt_dma_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_ready = dma_ready_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt_dma   = gnt_dma_q;

endmodule
